// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives program memory, captures the read into the IF/ID register.
// Latency: the instruction at PC_o appears on IF/ID one edge later; a redirect costs one bubble.
// Backpressure: Stall_i freezes PC and IF/ID; Flush_i/Redirect_i override it with a bubble.
module instruction_fetch_unit #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0040_0000,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Stall_i,
    input  logic                  Flush_i,
    input  logic                  Redirect_i,
    input  logic [DATA_WIDTH-1:0] Target_i,
    input  logic [DATA_WIDTH-1:0] Instruction_i,
    output logic [DATA_WIDTH-1:0] PC_o,
    output logic [DATA_WIDTH-1:0] IFID_Instruction_o,
    output logic [DATA_WIDTH-1:0] IFID_PC_o,
    output logic [DATA_WIDTH-1:0] IFID_PC_Plus4_o,
    output logic                  IFID_Valid_o,
    output logic                  Misaligned_o,
    output logic [DATA_WIDTH-1:0] Fetch_Count_o
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] instr;
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] pc_plus4;
        logic                  vld;
    } ifid_t;

    logic [DATA_WIDTH-1:0] r_pc;
    ifid_t                 r_ifid;
    logic                  r_misaligned;
    logic [DATA_WIDTH-1:0] r_fetch_cnt;

    logic [DATA_WIDTH-1:0] w_pc_plus4;
    logic [DATA_WIDTH-1:0] w_aligned_tgt;
    logic                  w_bubble;
    logic                  w_capture;

    assign w_pc_plus4    = r_pc + DATA_WIDTH'(4);
    assign w_aligned_tgt = {Target_i[DATA_WIDTH-1:2], 2'b00};
    assign w_bubble      = Redirect_i | Flush_i;
    assign w_capture     = ~w_bubble & ~Stall_i;

    // PC comes straight from a register so the combinational memory read cannot form a loop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (Redirect_i) begin
            r_pc <= w_aligned_tgt;
        end else if (!Stall_i) begin
            r_pc <= w_pc_plus4;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ifid <= '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, vld: 1'b0};
        end else if (w_bubble) begin
            r_ifid <= '{instr: NOP_INSTR, pc: r_pc, pc_plus4: w_pc_plus4, vld: 1'b0};
        end else if (!Stall_i) begin
            r_ifid <= '{instr: Instruction_i, pc: r_pc, pc_plus4: w_pc_plus4, vld: 1'b1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_misaligned <= 1'b0;
            r_fetch_cnt  <= '0;
        end else begin
            r_misaligned <= Redirect_i & (|Target_i[1:0]);
            if (w_capture) begin
                r_fetch_cnt <= r_fetch_cnt + DATA_WIDTH'(1);
            end
        end
    end

    assign PC_o               = r_pc;
    assign IFID_Instruction_o = r_ifid.instr;
    assign IFID_PC_o          = r_ifid.pc;
    assign IFID_PC_Plus4_o    = r_ifid.pc_plus4;
    assign IFID_Valid_o       = r_ifid.vld;
    assign Misaligned_o       = r_misaligned;
    assign Fetch_Count_o      = r_fetch_cnt;

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Front-end fetch stage that sits directly upstream of the program memory.
- Owns the program counter (PC) and drives the byte address into the program memory's Address_i.
- Captures the combinationally-read instruction into the IF/ID pipeline register and hands it to decode.
- Handles stall, flush and branch/jump redirect, and counts retired fetches for debug.

Parameters:
- DATA_WIDTH, 32, width of PC, instruction and target buses.
- RESET_PC, 32'h0040_0000, PC value loaded on reset (text segment base).
- NOP_INSTR, 32'h0000_0013, bubble instruction inserted on flush/redirect (addi x0,x0,0).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- Stall_i  input  1  hold PC and IF/ID contents
- Flush_i  input  1  replace IF/ID contents with bubble
- Redirect_i  input  1  load PC from Target_i (taken branch/jump)
- Target_i  input  DATA_WIDTH  redirect byte address
- Instruction_i  input  DATA_WIDTH  instruction from program memory (combinational, same cycle as PC_o)
- PC_o  output  DATA_WIDTH  current PC; wired to program memory Address_i
- IFID_Instruction_o  output  DATA_WIDTH  registered instruction
- IFID_PC_o  output  DATA_WIDTH  registered PC of that instruction
- IFID_PC_Plus4_o  output  DATA_WIDTH  registered PC+4 of that instruction
- IFID_Valid_o  output  1  IF/ID holds a real instruction
- Misaligned_o  output  1  one-cycle pulse: last redirect target had [1:0] != 0
- Fetch_Count_o  output  DATA_WIDTH  number of valid instructions captured into IF/ID

Behaviour:
- Reset (asynchronous, active-high, dominates everything):
  - PC_o=RESET_PC
  - IFID_Instruction_o=NOP_INSTR
  - IFID_PC_o=0, IFID_PC_Plus4_o=0
  - IFID_Valid_o=0, Misaligned_o=0, Fetch_Count_o=0
- PC update each rising edge, priority order:
  - Redirect_i=1: PC <= {Target_i[DW-1:2],2'b00}.
  - else Stall_i=1: PC holds.
  - else: PC <= PC+4, modulo 2^DATA_WIDTH (0xFFFF_FFFC wraps to 0x0000_0000).
- Redirect always overrides stall on the PC.
- IF/ID update each rising edge, priority order:
  - Redirect_i=1 or Flush_i=1: Instruction <= NOP_INSTR, Valid <= 0, PC/PC_Plus4 <= current PC/PC+4 (don't-care for decode).
  - else Stall_i=1: all IF/ID fields hold, Valid included.
  - else: Instruction <= Instruction_i, PC <= PC_o, PC_Plus4 <= PC_o+4, Valid <= 1.
- Flush overrides stall on IF/ID.
- Latency: an instruction at address A appears on IFID_Instruction_o exactly one cycle after PC_o=A, provided no stall, flush or redirect occurs in that cycle.
- Redirect cost: the instruction fetched in the redirect cycle is discarded (one bubble). The target instruction appears in IF/ID two edges after Redirect_i is sampled.
- Misaligned_o:
  - Registered; =1 for exactly one cycle after an edge where Redirect_i=1 and Target_i[1:0]!=0; otherwise 0.
  - The PC is still loaded with the word-aligned target. No other action is taken.
- Fetch_Count_o:
  - Increments by 1 on every edge where IF/ID captures with Valid <= 1.
  - Wraps modulo 2^DATA_WIDTH.
  - Holds on stall, flush, redirect.
- PC_o is driven directly from the PC register (no combinational path from any input). This breaks the loop through the combinational program memory.
- Reset deasserting mid-stream: the first post-reset edge behaves as a normal cycle from RESET_PC.
- Stall_i=1 and Flush_i=1 with Redirect_i=0: PC holds; IF/ID becomes a bubble.

Test Plan:
- Reset then 4 free-running cycles, memory returning 0xA0+addr:
  - PC_o = 0x0040_0000, _04, _08, _0C, _10.
  - IF/ID shows the instruction for 0x0040_0000 with Valid=1 after edge 1.
  - Fetch_Count_o=4 after edge 4.
- Stall_i=1 for 3 cycles at PC=0x0040_0008:
  - PC_o and all IF/ID outputs are frozen for 3 cycles.
  - Fetch_Count_o unchanged.
  - Sequential fetch resumes at 0x0040_0008→0x0040_000C on release.
- Redirect_i=1, Target_i=0x0040_0100, with Stall_i=1 in the same cycle:
  - Next PC_o=0x0040_0100.
  - IFID_Valid_o=0 and IFID_Instruction_o=0x0000_0013 for one cycle.
  - Target instruction valid on the following cycle.
- Redirect_i=1, Target_i=0x0040_0102:
  - PC_o=0x0040_0100.
  - Misaligned_o=1 for exactly one cycle, then 0.
- Flush_i=1 with Stall_i=1 at PC=0x0040_0020:
  - PC holds at 0x0040_0020.
  - IF/ID becomes NOP with Valid=0.
- Redirect to 0xFFFF_FFFC, then one free cycle:
  - PC_o wraps to 0x0000_0000.
  - Async reset asserted mid-cycle forces PC_o=0x0040_0000 and IFID_Valid_o=0 before the next clock edge.
